priority_arbiter_rr: RTL and testbench

Parametrised, registered successor to the combinational 8-input priority encoder. Accepts an N-bit request vector and selects one requester, either by fixed priority (highest index wins) or by round-robin. It presents the result as a held, one-hot plus binary grant on a valid/ready handshake. It sits between request-generating logic and a shared resource, for example a bus or a port mux, and sustains one grant per cycle under no backpressure.

---
 rtl/priority_arbiter_rr.sv | 100 ++++++++++
 tb/tb_priority_arbiter_rr.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter_rr.sv
// priority_arbiter_rr: registered N-way arbiter with fixed-priority or
// round-robin selection. It presents a held one-hot plus binary grant on a
// valid/ready handshake. Every output is a flop.
module priority_arbiter_rr #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         rr_mode,
  input  logic [N-1:0] req,
  output logic         grant_valid,
  input  logic         grant_ready,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state;
  logic [W-1:0]   ptr;
  logic [W-1:0]   base;
  logic [W-1:0]   cand;
  logic [W-1:0]   sel_idx;
  logic [N-1:0]   sel_onehot;
  logic           sel_hit;
  logic           start;
  int             pos;

  // Selection search. On an accept the pointer is about to become grant_idx,
  // so the same-cycle re-arbitration uses grant_idx directly as its base.
  // A zero base reproduces fixed priority (N-1 down to 0).
  always_comb begin
    base    = '0;
    sel_hit = 1'b0;
    sel_idx = '0;
    pos     = 0;
    cand    = '0;
    if (rr_mode)
      base = (state == GRANT) ? grant_idx : ptr;
    for (int k = 1; k <= N; k++) begin
      pos = int'(base) - k;
      if (pos < 0)
        pos = pos + N;
      cand = W'(pos);
      if (!sel_hit && req[cand]) begin
        sel_hit = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // One-hot form of the selected index (only consumed when sel_hit is set).
  always_comb begin
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
  end

  assign start = en && sel_hit;

  // FSM and registered grant outputs. Reset wins over a pending accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= GRANT;
            grant_valid  <= 1'b1;
            grant_idx    <= sel_idx;
            grant_onehot <= sel_onehot;
          end
        end
        GRANT: begin
          // Without an accept everything holds, whatever req/en/rr_mode do.
          if (grant_ready) begin
            ptr <= grant_idx;
            if (start) begin
              grant_idx    <= sel_idx;
              grant_onehot <= sel_onehot;
            end else begin
              state        <= IDLE;
              grant_valid  <= 1'b0;
              grant_idx    <= '0;
              grant_onehot <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Self-checking bench for priority_arbiter_rr: table-driven per-cycle vectors
// for an N=8 and an N=5 instance, expected outputs queued when a vector is
// driven and popped for comparison after the clock edge.
module tb_priority_arbiter_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance
  logic       rst8, en8, rr8, rdy8;
  logic [7:0] req8;
  logic       gv8;
  logic [2:0] gi8;
  logic [7:0] go8;

  // N=5 instance
  logic       rst5, en5, rr5, rdy5;
  logic [4:0] req5;
  logic       gv5;
  logic [2:0] gi5;
  logic [4:0] go5;

  priority_arbiter_rr #(.N(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .rr_mode(rr8), .req(req8),
    .grant_valid(gv8), .grant_ready(rdy8), .grant_idx(gi8), .grant_onehot(go8)
  );

  priority_arbiter_rr #(.N(5)) dut5 (
    .clk(clk), .rst(rst5), .en(en5), .rr_mode(rr5), .req(req5),
    .grant_valid(gv5), .grant_ready(rdy5), .grant_idx(gi5), .grant_onehot(go5)
  );

  typedef struct {
    logic       rst, en, rr, rdy;
    logic [7:0] req;
    logic       vld;   // expected grant_valid after the edge
    int         idx;   // expected grant_idx after the edge
  } vec_t;

  typedef struct {
    logic       vld;
    logic [2:0] idx;
    logic [7:0] oh;
  } exp_t;

  vec_t t8[$];
  vec_t t5[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(bit r, bit e, bit m, logic [7:0] q, bit rd, bit ev, int ei);
    vec_t x;
    x.rst = r; x.en = e; x.rr = m; x.req = q; x.rdy = rd; x.vld = ev; x.idx = ei;
    return x;
  endfunction

  task automatic check(string nm, int act, int req_v);
    total++;
    if (act != req_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req_v);
    end
  endtask

  task automatic apply(vec_t t, bit five, int n);
    exp_t e;
    logic [7:0] one;
    string tag;
    @(negedge clk);
    if (five) begin
      rst5 = t.rst; en5 = t.en; rr5 = t.rr; rdy5 = t.rdy; req5 = t.req[4:0];
    end else begin
      rst8 = t.rst; en8 = t.en; rr8 = t.rr; rdy8 = t.rdy; req8 = t.req;
    end
    one   = 8'd1;
    e.vld = t.vld;
    e.idx = t.vld ? 3'(t.idx) : 3'd0;
    e.oh  = t.vld ? (one << t.idx) : 8'd0;
    if (five) e.oh = e.oh & 8'h1F;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    tag = $sformatf("%s[%0d]", five ? "n5" : "n8", n);
    if (five) begin
      check({tag, ".valid"},  int'(gv5), int'(e.vld));
      check({tag, ".idx"},    int'(gi5), int'(e.idx));
      check({tag, ".onehot"}, int'(go5), int'(e.oh));
      check({tag, ".idx_lt_5"}, int'(gi5 < 3'd5), 1);
    end else begin
      check({tag, ".valid"},  int'(gv8), int'(e.vld));
      check({tag, ".idx"},    int'(gi8), int'(e.idx));
      check({tag, ".onehot"}, int'(go8), int'(e.oh));
    end
  endtask

  initial begin
    rst8 = 1'b1; en8 = 1'b0; rr8 = 1'b0; rdy8 = 1'b0; req8 = '0;
    rst5 = 1'b1; en5 = 1'b0; rr5 = 1'b0; rdy5 = 1'b0; req5 = '0;

    //            rst en rr req    rdy  vld idx
    // reset, enable/empty
    t8.push_back(v(1, 0, 0, 8'h00, 0,   0, 0));
    t8.push_back(v(1, 0, 0, 8'h00, 0,   0, 0));
    t8.push_back(v(0, 0, 0, 8'hFF, 1,   0, 0));
    t8.push_back(v(0, 0, 0, 8'hFF, 1,   0, 0));
    t8.push_back(v(0, 1, 0, 8'h00, 1,   0, 0));
    // fixed priority, req=0010_0110, ready held
    t8.push_back(v(0, 1, 0, 8'h26, 1,   1, 5));
    t8.push_back(v(0, 1, 0, 8'h26, 1,   1, 5));
    t8.push_back(v(0, 1, 0, 8'h26, 1,   1, 5));
    // backpressure: grant 2, then req moves to 0x80 while stalled
    t8.push_back(v(0, 1, 0, 8'h04, 1,   1, 2));
    t8.push_back(v(0, 1, 0, 8'h80, 0,   1, 2));
    t8.push_back(v(0, 1, 0, 8'h80, 0,   1, 2));
    t8.push_back(v(0, 1, 0, 8'h80, 0,   1, 2));
    t8.push_back(v(0, 1, 0, 8'h80, 1,   1, 7));
    // en and req dropped during GRANT: held until accept, then IDLE
    t8.push_back(v(0, 0, 0, 8'h80, 0,   1, 7));
    t8.push_back(v(0, 0, 0, 8'h00, 0,   1, 7));
    t8.push_back(v(0, 0, 0, 8'h00, 1,   0, 0));
    t8.push_back(v(0, 0, 0, 8'hFF, 1,   0, 0));
    // round-robin continues from last accepted (7) -> 6, then reset mid-grant
    t8.push_back(v(0, 1, 1, 8'hFF, 0,   1, 6));
    t8.push_back(v(1, 1, 1, 8'hFF, 1,   0, 0));
    t8.push_back(v(1, 1, 1, 8'hFF, 1,   0, 0));
    // round-robin sweep from ptr=0
    t8.push_back(v(0, 1, 1, 8'hFF, 1,   1, 7));
    t8.push_back(v(0, 1, 1, 8'hFF, 1,   1, 6));
    t8.push_back(v(0, 1, 1, 8'hFF, 1,   1, 5));
    t8.push_back(v(0, 1, 1, 8'hFF, 1,   1, 4));
    t8.push_back(v(0, 1, 1, 8'hFF, 1,   1, 3));
    t8.push_back(v(0, 1, 1, 8'hFF, 1,   1, 2));
    t8.push_back(v(0, 1, 1, 8'hFF, 1,   1, 1));
    t8.push_back(v(0, 1, 1, 8'hFF, 1,   1, 0));
    t8.push_back(v(0, 1, 1, 8'hFF, 1,   1, 7));
    // sparse round-robin, then a fixed-mode grant that still moves ptr
    t8.push_back(v(0, 1, 1, 8'h09, 1,   1, 3));
    t8.push_back(v(0, 1, 1, 8'h09, 1,   1, 0));
    t8.push_back(v(0, 1, 1, 8'h09, 1,   1, 3));
    t8.push_back(v(0, 1, 0, 8'h09, 1,   1, 3));
    t8.push_back(v(0, 1, 1, 8'h09, 1,   1, 0));
    t8.push_back(v(0, 1, 1, 8'h00, 1,   0, 0));
    t8.push_back(v(0, 1, 1, 8'h00, 1,   0, 0));

    // N=5 round-robin wrap, single requester re-granted, fixed mode
    t5.push_back(v(1, 0, 0, 8'h00, 0,   0, 0));
    t5.push_back(v(0, 1, 1, 8'h1F, 1,   1, 4));
    t5.push_back(v(0, 1, 1, 8'h1F, 1,   1, 3));
    t5.push_back(v(0, 1, 1, 8'h1F, 1,   1, 2));
    t5.push_back(v(0, 1, 1, 8'h1F, 1,   1, 1));
    t5.push_back(v(0, 1, 1, 8'h1F, 1,   1, 0));
    t5.push_back(v(0, 1, 1, 8'h1F, 1,   1, 4));
    t5.push_back(v(0, 1, 1, 8'h01, 1,   1, 0));
    t5.push_back(v(0, 1, 1, 8'h01, 1,   1, 0));
    t5.push_back(v(0, 1, 0, 8'h1F, 1,   1, 4));
    t5.push_back(v(0, 0, 0, 8'h1F, 1,   0, 0));

    for (int i = 0; i < t8.size(); i++) apply(t8[i], 1'b0, i);
    for (int i = 0; i < t5.size(); i++) apply(t5[i], 1'b1, i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
